fifo_sync_fc: RTL and testbench

Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through read mode and sticky overflow/underflow error flags. Next-generation buffer for all single-clock-domain producer/consumer links. Depth is any integer ≥ 2, not only powers of two. Accepts a write into a full FIFO when a read happens in the same cycle.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_sync_fc_if.sv | 26 ++
 rtl/fifo_mem.sv | 18 +
 rtl/fifo_sync_fc.sv | 69 ++++++
 tb/tb_fifo_sync_fc.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and read-mode constants for the fifo_sync_fc family
package fifo_pkg;
  localparam int FIFO_STD = 0;
  localparam int FIFO_FWFT = 1;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  // count must hold DEPTH itself, hence the +1
  function automatic int cwidth(input int depth);
    return clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_sync_fc_if.sv
// fifo_sync_fc_if: producer/consumer handshake and status bundle of the single-clock fifo
interface fifo_sync_fc_if #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 6
);
  logic              wr_en;
  logic [DWIDTH-1:0] data_in;
  logic              rd_en;
  logic              clr_err;
  logic [DWIDTH-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CWIDTH-1:0] count;
  logic              overflow;
  logic              underflow;
  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DWIDTH storage, synchronous write port, asynchronous read port
module fifo_mem #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = fifo_pkg::clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);
  logic [DWIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_sync_fc.sv
// fifo_sync_fc: single-clock fifo with count, threshold flags, optional FWFT and sticky error flags
module fifo_sync_fc
  import fifo_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 32,
  parameter int FWFT     = FIFO_STD,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input logic clk,
  input logic rst,
  fifo_sync_fc_if.slave bus
);
  localparam int CWIDTH = cwidth(DEPTH);
  localparam int PW = clog2(DEPTH);
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic [DWIDTH-1:0] dout_q, dout_d, rdata;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              full, empty, wr_acc, rd_acc;
  assign full  = count_q == CWIDTH'(DEPTH);
  assign empty = count_q == '0;
  // a full fifo still takes a write when the same cycle pops a word
  assign wr_acc = bus.wr_en && (!full || bus.rd_en);
  assign rd_acc = bus.rd_en && !empty;
  always_comb begin
    wptr_d  = wr_acc ? (wptr_q == PW'(DEPTH - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d  = rd_acc ? (rptr_q == PW'(DEPTH - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
    count_d = (wr_acc && !rd_acc) ? count_q + 1'b1 :
              (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
    ovf_d   = (bus.wr_en && full && !bus.rd_en) || (ovf_q && !bus.clr_err);
    udf_d   = (bus.rd_en && empty) || (udf_q && !bus.clr_err);
    dout_d  = rd_acc ? rdata : dout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end
  fifo_mem #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );
  assign bus.data_out     = (FWFT == FIFO_FWFT) ? rdata : dout_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = count_q >= CWIDTH'(AF_LEVEL);
  assign bus.almost_empty = count_q <= CWIDTH'(AE_LEVEL);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_fc.sv
// tb_fifo_sync_fc: standard and FWFT depth-5 fifos driven in lockstep against a queue model
module tb_fifo_sync_fc;
  import fifo_pkg::*;
  localparam int DEPTH = 5;
  localparam int CW = cwidth(DEPTH);
  localparam int AF = DEPTH - 4;
  localparam int AE = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_dout = '0;
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;
  fifo_sync_fc_if #(.DWIDTH(8), .CWIDTH(CW)) bs(), bf();
  fifo_sync_fc #(.DWIDTH(8), .DEPTH(DEPTH), .FWFT(FIFO_STD)) u_std (.clk(clk), .rst(rst), .bus(bs));
  fifo_sync_fc #(.DWIDTH(8), .DEPTH(DEPTH), .FWFT(FIFO_FWFT)) u_fw (.clk(clk), .rst(rst), .bus(bf));
  always #5 clk = ~clk;

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit was_full, was_empty;
    bs.wr_en = w; bs.data_in = d; bs.rd_en = r; bs.clr_err = c;
    bf.wr_en = w; bf.data_in = d; bf.rd_en = r; bf.clr_err = c;
    @(posedge clk);
    was_full = m_q.size() == DEPTH;
    was_empty = m_q.size() == 0;
    if (r && !was_empty) m_dout = m_q.pop_front();
    if (w && (!was_full || r)) m_q.push_back(d);
    m_ovf = (w && was_full && !r) || (m_ovf && !c);
    m_udf = (r && was_empty) || (m_udf && !c);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    rst = 1'b0;
    m_q.delete(); m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if ({bs.empty, bs.full, bs.almost_empty, bs.almost_full} !== 4'b1010) begin n_fail++; $display("FAIL reset_std_flags: got %b expected 1010", {bs.empty, bs.full, bs.almost_empty, bs.almost_full}); end
    n_tests++; if ({bf.empty, bf.full, bf.almost_empty, bf.almost_full} !== 4'b1010) begin n_fail++; $display("FAIL reset_fw_flags: got %b expected 1010", {bf.empty, bf.full, bf.almost_empty, bf.almost_full}); end
    n_tests++; if (bs.count !== '0 || bf.count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d/%0d expected 0", bs.count, bf.count); end
    n_tests++; if ({bs.overflow, bs.underflow, bf.overflow, bf.underflow} !== 4'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0000", {bs.overflow, bs.underflow, bf.overflow, bf.underflow}); end
    n_tests++; if (bs.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", bs.data_out); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'h11 + i), 0, 0);
    n_tests++; if ({bs.full, bs.almost_full, bs.empty} !== 3'b110) begin n_fail++; $display("FAIL fill_flags: got %b expected 110", {bs.full, bs.almost_full, bs.empty}); end
    n_tests++; if (bs.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", bs.count, DEPTH); end
    n_tests++; if (bf.data_out !== 8'h11) begin n_fail++; $display("FAIL fill_fw_head: got %h expected 11", bf.data_out); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 8'h00, 1, 0);
      n_tests++; if (bs.data_out !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL drain_dout[%0d]: got %h expected %h", i, bs.data_out, 8'(8'h11 + i)); end
      if (m_q.size() > 0) begin
        n_tests++; if (bf.data_out !== m_q[0]) begin n_fail++; $display("FAIL drain_fw_head[%0d]: got %h expected %h", i, bf.data_out, m_q[0]); end
      end
    end
    n_tests++; if (bs.empty !== 1'b1 || bf.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b/%b expected 1", bs.empty, bf.empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      drive(1, d, 0, 0);
      n_tests++; if (bf.data_out !== d || bf.empty !== 1'b0) begin n_fail++; $display("FAIL wrap_fw[%0d]: got %h empty=%b expected %h", i, bf.data_out, bf.empty, d); end
      drive(0, 8'h00, 1, 0);
      n_tests++; if (bs.data_out !== d) begin n_fail++; $display("FAIL wrap_std[%0d]: got %h expected %h", i, bs.data_out, d); end
    end
    n_tests++; if ({bs.overflow, bs.underflow, bs.count} !== {2'b0, CW'(0)}) begin n_fail++; $display("FAIL wrap_state: got ovf=%b udf=%b cnt=%0d expected 0 0 0", bs.overflow, bs.underflow, bs.count); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'h21 + i), 0, 0);
    drive(1, 8'hA5, 1, 0);
    n_tests++; if (bs.count !== CW'(DEPTH) || bs.full !== 1'b1) begin n_fail++; $display("FAIL fullrw_count: got %0d full=%b expected %0d full=1", bs.count, bs.full, DEPTH); end
    n_tests++; if (bs.data_out !== 8'h21 || bs.overflow !== 1'b0) begin n_fail++; $display("FAIL fullrw_pop: got %h ovf=%b expected 21 ovf=0", bs.data_out, bs.overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 8'h00, 1, 0);
      n_tests++; if (bs.data_out !== m_dout) begin n_fail++; $display("FAIL fullrw_drain[%0d]: got %h expected %h", i, bs.data_out, m_dout); end
    end
    n_tests++; if (bs.data_out !== 8'hA5) begin n_fail++; $display("FAIL fullrw_last: got %h expected a5", bs.data_out); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'h31 + i), 0, 0);
    drive(1, 8'h99, 0, 0);
    n_tests++; if ({bs.overflow, bs.underflow, bf.overflow} !== 3'b101) begin n_fail++; $display("FAIL ovf_set: got %b expected 101", {bs.overflow, bs.underflow, bf.overflow}); end
    n_tests++; if (bs.count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", bs.count, DEPTH); end
    drive(0, 8'h00, 0, 0);
    n_tests++; if (bs.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bs.overflow); end
    drive(0, 8'h00, 0, 1);
    n_tests++; if (bs.overflow !== 1'b0 || bf.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b/%b expected 0", bs.overflow, bf.overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 8'h00, 1, 0);
      n_tests++; if (bs.data_out !== 8'(8'h31 + i)) begin n_fail++; $display("FAIL ovf_contents[%0d]: got %h expected %h", i, bs.data_out, 8'(8'h31 + i)); end
    end
    drive(0, 8'h00, 1, 0);
    n_tests++; if (bs.underflow !== 1'b1 || bf.underflow !== 1'b1 || bs.data_out !== 8'h35) begin n_fail++; $display("FAIL udf_set: got udf=%b/%b dout=%h expected 1/1 35", bs.underflow, bf.underflow, bs.data_out); end
    drive(0, 8'h00, 1, 1);
    n_tests++; if (bs.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_set_wins: got %b expected 1", bs.underflow); end
    drive(0, 8'h00, 0, 1);
    drive(1, 8'h5A, 1, 0);
    n_tests++; if (bs.underflow !== 1'b1 || bs.count !== CW'(1)) begin n_fail++; $display("FAIL empty_rw: got udf=%b cnt=%0d expected 1 1", bs.underflow, bs.count); end
    drive(0, 8'h00, 1, 1);
    n_tests++; if (bs.underflow !== 1'b0 || bs.data_out !== 8'h5A) begin n_fail++; $display("FAIL empty_rw_data: got udf=%b dout=%h expected 0 5a", bs.underflow, bs.data_out); end
  endtask

  task automatic test_fwft();
    drive(1, 8'h3C, 0, 0);
    n_tests++; if (bf.empty !== 1'b0 || bf.data_out !== 8'h3C) begin n_fail++; $display("FAIL fwft_show: got empty=%b dout=%h expected 0 3c", bf.empty, bf.data_out); end
    drive(0, 8'h00, 1, 0);
    n_tests++; if (bf.empty !== 1'b1 || bf.underflow !== 1'b0) begin n_fail++; $display("FAIL fwft_pop: got empty=%b udf=%b expected 1 0", bf.empty, bf.underflow); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(1, 8'(8'h41 + i), 0, 0);
    drive(1, 8'h00, 0, 0);
    drive(1, 8'h00, 0, 0);
    drive(1, 8'h00, 0, 0);
    do_reset();
    n_tests++; if ({bs.empty, bs.full, bs.almost_empty, bs.almost_full, bs.overflow, bs.underflow} !== 6'b101000) begin n_fail++; $display("FAIL midrst_flags: got %b expected 101000", {bs.empty, bs.full, bs.almost_empty, bs.almost_full, bs.overflow, bs.underflow}); end
    n_tests++; if (bs.count !== '0 || bs.data_out !== 8'h00 || bf.count !== '0) begin n_fail++; $display("FAIL midrst_state: got cnt=%0d dout=%h expected 0 00", bs.count, bs.data_out); end
    drive(1, 8'h77, 0, 0);
    n_tests++; if (bf.data_out !== 8'h77) begin n_fail++; $display("FAIL midrst_fw: got %h expected 77", bf.data_out); end
    drive(0, 8'h00, 1, 0);
    n_tests++; if (bs.data_out !== 8'h77 || bs.empty !== 1'b1) begin n_fail++; $display("FAIL midrst_std: got %h empty=%b expected 77 1", bs.data_out, bs.empty); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      n_tests++; if (bs.count !== CW'(m_q.size()) || bf.count !== CW'(m_q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d/%0d expected %0d", i, bs.count, bf.count, m_q.size()); end
      n_tests++; if (bs.data_out !== m_dout) begin n_fail++; $display("FAIL rnd_dout[%0d]: got %h expected %h", i, bs.data_out, m_dout); end
      n_tests++; if ({bs.overflow, bs.underflow} !== {m_ovf, m_udf}) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b%b expected %b%b", i, bs.overflow, bs.underflow, m_ovf, m_udf); end
      n_tests++;
      if ({bs.full, bs.empty, bs.almost_full, bs.almost_empty} !== {m_q.size() == DEPTH, m_q.size() == 0, m_q.size() >= AF, m_q.size() <= AE}) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: got %b with count %0d", i, {bs.full, bs.empty, bs.almost_full, bs.almost_empty}, m_q.size());
      end
      if (m_q.size() > 0) begin
        n_tests++; if (bf.data_out !== m_q[0]) begin n_fail++; $display("FAIL rnd_fw[%0d]: got %h expected %h", i, bf.data_out, m_q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_rw();
    test_errors();
    test_fwft();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
